execute_pipe: RTL and testbench

Parametrised, handshaked execute stage for the pipelined core. It sits between decode and writeback/memory. It evaluates single-cycle ALU ops, resolves branches and jumps (taken flag plus target PC), and runs an iterative unsigned divider for DIVU/REMU. All results leave through one registered output slot with valid/ready flow control and a synchronous flush.

---
 rtl/exec_pkg.sv | 34 +++
 rtl/div_iter.sv | 78 +++++++
 rtl/execute_pipe.sv | 165 ++++++++++++++++
 tb/tb_execute_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: opcode encoding,
// divider FSM states and the PC increment.
package exec_pkg;

    typedef enum logic [4:0] {
        ADD  = 5'd0,
        SUB  = 5'd1,
        AND  = 5'd2,
        OR   = 5'd3,
        XOR  = 5'd4,
        SLT  = 5'd5,
        SLTU = 5'd6,
        SLL  = 5'd7,
        SRL  = 5'd8,
        SRA  = 5'd9,
        ADDI = 5'd10,
        BEQ  = 5'd11,
        BNE  = 5'd12,
        BLT  = 5'd13,
        J    = 5'd14,
        JAL  = 5'd15,
        JR   = 5'd16,
        DIVU = 5'd17,
        REMU = 5'd18
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } div_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/div_iter.sv
// Restoring unsigned divider: one quotient bit per cycle, XLEN iterations,
// then holds the result until the consumer acknowledges it.
module div_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            start,
    input  logic            ack,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            idle,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN + 1);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dsr;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic             last;

    assign last = (count == CNT_W'(XLEN));

    // Borrow out of the trial subtraction means the divisor did not fit.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dsr};
    end

    // NOTE: only the control state is reset; the datapath registers are
    // always loaded on start before they are read, so they need no reset.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DIV;
                        count <= '0;
                        quo   <= dividend;
                        rem   <= '0;
                        dsr   <= divisor;
                    end
                end
                DIV: begin
                    if (!last) begin
                        count <= count + 1'b1;
                        quo   <= {quo[XLEN-2:0], ~diff[XLEN]};
                        rem   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                    end else if (ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign idle      = (state == IDLE);
    assign busy      = (state == DIV) && (count != '0);
    assign done      = (state == DIV) && last;
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/execute_pipe.sv
// Execute stage: single-cycle ALU and branch resolution, iterative DIVU/REMU,
// and one registered valid/ready output slot with synchronous flush.
module execute_pipe
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int SH_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  op_t             in_op,
    input  logic [PC_W-1:0] in_pc,
    input  logic [XLEN-1:0] in_s,
    input  logic [XLEN-1:0] in_t,
    input  logic [XLEN-1:0] in_imm,
    input  logic [SH_W-1:0] in_h,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_d,
    output logic [4:0]      out_rd,
    output logic            out_br_taken,
    output logic [PC_W-1:0] out_bpc,
    output logic            busy
);

    localparam logic [PC_W-1:0] PC_HI_MASK = {4'hF, {(PC_W-4){1'b0}}};

    logic            div_idle;
    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic            div_is_rem;
    logic [4:0]      div_rd;

    logic            slot_free;
    logic            accept;
    logic            is_iter_div;
    logic            start_div;
    logic            load_alu;
    logic            load_div;

    logic [XLEN-1:0] alu_d;
    logic            alu_taken;
    logic [PC_W-1:0] alu_bpc;
    logic [XLEN-1:0] imm_sh;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;

    assign slot_free   = !out_valid || out_ready;
    assign in_ready    = !rst && !flush && div_idle && slot_free;
    assign accept      = in_valid && in_ready;
    assign is_iter_div = ((in_op == DIVU) || (in_op == REMU)) && (in_t != '0);
    assign start_div   = accept && is_iter_div;
    assign load_alu    = accept && !is_iter_div;
    assign load_div    = div_done && slot_free && !flush;

    assign imm_sh    = in_imm << 2;
    assign pc_plus4  = in_pc + PC_W'(PC_STEP);
    assign br_target = pc_plus4 + PC_W'($signed(imm_sh));
    assign j_target  = (in_pc & PC_HI_MASK) | PC_W'($signed(imm_sh));

    always_comb begin
        alu_d     = '0;
        alu_taken = 1'b0;
        alu_bpc   = '0;
        case (in_op)
            ADD:  alu_d = in_s + in_t;
            SUB:  alu_d = in_s - in_t;
            AND:  alu_d = in_s & in_t;
            OR:   alu_d = in_s | in_t;
            XOR:  alu_d = in_s ^ in_t;
            SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(in_s) < $signed(in_t)};
            SLTU: alu_d = {{(XLEN-1){1'b0}}, in_s < in_t};
            SLL:  alu_d = in_s << in_h;
            SRL:  alu_d = in_s >> in_h;
            SRA:  alu_d = $signed(in_s) >>> in_h;
            ADDI: alu_d = in_s + in_imm;
            BEQ: begin
                alu_taken = (in_s == in_t);
                alu_bpc   = alu_taken ? br_target : '0;
            end
            BNE: begin
                alu_taken = (in_s != in_t);
                alu_bpc   = alu_taken ? br_target : '0;
            end
            BLT: begin
                alu_taken = $signed(in_s) < $signed(in_t);
                alu_bpc   = alu_taken ? br_target : '0;
            end
            J: begin
                alu_taken = 1'b1;
                alu_bpc   = j_target;
            end
            JAL: begin
                alu_taken = 1'b1;
                alu_bpc   = j_target;
                alu_d     = XLEN'(pc_plus4);
            end
            JR: begin
                alu_taken = 1'b1;
                alu_bpc   = PC_W'(in_s);
            end
            // Only reach the slot on divide-by-zero; nonzero divisors iterate.
            DIVU: alu_d = '1;
            REMU: alu_d = in_s;
            default: alu_d = '0;
        endcase
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (start_div),
        .ack       (load_div),
        .dividend  (in_s),
        .divisor   (in_t),
        .idle      (div_idle),
        .busy      (busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (start_div) begin
            div_is_rem <= (in_op == REMU);
            div_rd     <= in_rd;
        end
    end

    // Flush outranks everything; a stalled slot keeps its payload untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_d        <= '0;
            out_rd       <= '0;
            out_br_taken <= 1'b0;
            out_bpc      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_alu) begin
            out_valid    <= 1'b1;
            out_d        <= alu_d;
            out_rd       <= in_rd;
            out_br_taken <= alu_taken;
            out_bpc      <= alu_bpc;
        end else if (load_div) begin
            out_valid    <= 1'b1;
            out_d        <= div_is_rem ? div_rem : div_quo;
            out_rd       <= div_rd;
            out_br_taken <= 1'b0;
            out_bpc      <= '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed testbench for execute_pipe: ALU, branches, jumps, divider,
// backpressure, flush and reset, with hand-computed expected values.
module tb_execute_pipe;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    logic [31:0] in_pc;
    logic [31:0] in_s;
    logic [31:0] in_t;
    logic [31:0] in_imm;
    logic [4:0]  in_h;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic [4:0]  out_rd;
    logic        out_br_taken;
    logic [31:0] out_bpc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    execute_pipe #(.XLEN(32), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_pc        (in_pc),
        .in_s         (in_s),
        .in_t         (in_t),
        .in_imm       (in_imm),
        .in_h         (in_h),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_d        (out_d),
        .out_rd       (out_rd),
        .out_br_taken (out_br_taken),
        .out_bpc      (out_bpc),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t op, input logic [31:0] pc, input logic [31:0] s,
                         input logic [31:0] t, input logic [31:0] imm,
                         input logic [4:0] h, input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_pc    = pc;
        in_s     = s;
        in_t     = t;
        in_imm   = imm;
        in_h     = h;
        in_rd    = rd;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic [4:0] rd,
                              input logic taken, input logic [31:0] bpc);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".d"}, out_d, d);
        check({tag, ".rd"}, out_rd, rd);
        check({tag, ".taken"}, out_br_taken, taken);
        check({tag, ".bpc"}, out_bpc, bpc);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(ADD, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        in_valid  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_d", out_d, 32'h0);
        check("rst.out_rd", out_rd, 5'd0);
        check("rst.taken", out_br_taken, 1'b0);
        check("rst.bpc", out_bpc, 32'h0);
        check("rst.busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", in_ready, 1'b1);

        // Back-to-back single-cycle ops at full throughput
        drive(ADD, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd3);
        tick();
        expect_out("add", 32'h8000_0000, 5'd3, 1'b0, 32'h0);
        drive(SRA, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 5'd4, 5'd4);
        tick();
        expect_out("sra", 32'hF800_0000, 5'd4, 1'b0, 32'h0);
        drive(SRL, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 5'd4, 5'd5);
        tick();
        expect_out("srl", 32'h0800_0000, 5'd5, 1'b0, 32'h0);
        drive(SLL, 32'h0, 32'h1, 32'h0, 32'h0, 5'd31, 5'd6);
        tick();
        expect_out("sll", 32'h8000_0000, 5'd6, 1'b0, 32'h0);
        drive(SUB, 32'h0, 32'h3, 32'h5, 32'h0, 5'd0, 5'd7);
        tick();
        expect_out("sub", 32'hFFFF_FFFE, 5'd7, 1'b0, 32'h0);
        drive(XOR, 32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'd0, 5'd8);
        tick();
        expect_out("xor", 32'h0FF0_0FF0, 5'd8, 1'b0, 32'h0);
        drive(SLT, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd9);
        tick();
        expect_out("slt", 32'h1, 5'd9, 1'b0, 32'h0);
        drive(SLTU, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd10);
        tick();
        expect_out("sltu", 32'h0, 5'd10, 1'b0, 32'h0);
        drive(ADDI, 32'h0, 32'd10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd11);
        tick();
        expect_out("addi", 32'd9, 5'd11, 1'b0, 32'h0);
        drive(BEQ, 32'h100, 32'd5, 32'd5, 32'd3, 5'd0, 5'd0);
        tick();
        expect_out("beq", 32'h0, 5'd0, 1'b1, 32'h110);
        drive(BNE, 32'h100, 32'd5, 32'd5, 32'd3, 5'd0, 5'd0);
        tick();
        expect_out("bne", 32'h0, 5'd0, 1'b0, 32'h0);
        drive(BLT, 32'h200, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 5'd0, 5'd0);
        tick();
        expect_out("blt", 32'h0, 5'd0, 1'b1, 32'h200);
        drive(JAL, 32'h4000_0010, 32'h0, 32'h0, 32'h20, 5'd0, 5'd31);
        tick();
        expect_out("jal", 32'h4000_0014, 5'd31, 1'b1, 32'h4000_0080);
        drive(J, 32'h8000_0000, 32'h0, 32'h0, 32'h0100_0000, 5'd0, 5'd0);
        tick();
        expect_out("j", 32'h0, 5'd0, 1'b1, 32'h8400_0000);
        drive(JR, 32'h0, 32'h1234, 32'h0, 32'h0, 5'd0, 5'd0);
        tick();
        expect_out("jr", 32'h0, 5'd0, 1'b1, 32'h1234);
        drive(op_t'(5'd25), 32'h0, 32'd5, 32'd6, 32'd7, 5'd1, 5'd2);
        tick();
        expect_out("undef", 32'h0, 5'd2, 1'b0, 32'h0);
        in_valid = 1'b0;
        tick();
        check("drain.out_valid", out_valid, 1'b0);

        // Iterative divide: busy for 32 cycles, result 33 edges after accept
        drive(DIVU, 32'h0, 32'd100, 32'd7, 32'h0, 5'd0, 5'd12);
        tick();
        in_valid = 1'b0;
        check("divu.busy_at_accept", busy, 1'b0);
        check("divu.in_ready", in_ready, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            check("divu.busy", busy, 1'b1);
            check("divu.out_valid_early", out_valid, 1'b0);
            check("divu.in_ready_busy", in_ready, 1'b0);
        end
        tick();
        check("divu.busy_end", busy, 1'b0);
        expect_out("divu", 32'd14, 5'd12, 1'b0, 32'h0);

        // Pop and new divide accept in the same cycle
        drive(REMU, 32'h0, 32'd100, 32'd7, 32'h0, 5'd0, 5'd13);
        tick();
        in_valid = 1'b0;
        check("remu.popped", out_valid, 1'b0);
        repeat (33) tick();
        expect_out("remu", 32'd2, 5'd13, 1'b0, 32'h0);

        drive(DIVU, 32'h0, 32'hFFFF_FFFF, 32'd3, 32'h0, 5'd0, 5'd14);
        tick();
        in_valid = 1'b0;
        repeat (33) tick();
        expect_out("divu_big", 32'h5555_5555, 5'd14, 1'b0, 32'h0);

        // Divide by zero: single-cycle latency, back to back
        drive(DIVU, 32'h0, 32'h55, 32'h0, 32'h0, 5'd0, 5'd15);
        tick();
        check("div0.busy", busy, 1'b0);
        expect_out("divu0", 32'hFFFF_FFFF, 5'd15, 1'b0, 32'h0);
        drive(REMU, 32'h0, 32'h55, 32'h0, 32'h0, 5'd0, 5'd16);
        tick();
        expect_out("remu0", 32'h55, 5'd16, 1'b0, 32'h0);
        in_valid = 1'b0;
        tick();

        // Backpressure: slot holds, producer stalls, then drains in order
        out_ready = 1'b0;
        drive(ADD, 32'h0, 32'd1, 32'd2, 32'h0, 5'd0, 5'd1);
        tick();
        expect_out("bp.a", 32'd3, 5'd1, 1'b0, 32'h0);
        drive(ADD, 32'h0, 32'd10, 32'd20, 32'h0, 5'd0, 5'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp.hold_in_ready", in_ready, 1'b0);
            expect_out("bp.hold", 32'd3, 5'd1, 1'b0, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_in_ready", in_ready, 1'b1);
        tick();
        expect_out("bp.b", 32'd30, 5'd2, 1'b0, 32'h0);
        drive(ADD, 32'h0, 32'd100, 32'd200, 32'h0, 5'd0, 5'd3);
        tick();
        expect_out("bp.c", 32'd300, 5'd3, 1'b0, 32'h0);
        in_valid = 1'b0;
        tick();
        check("bp.empty", out_valid, 1'b0);

        // Flush during a divide discards it; next op goes straight in
        drive(DIVU, 32'h0, 32'd100, 32'd7, 32'h0, 5'd0, 5'd20);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("flush.busy_before", busy, 1'b1);
        flush = 1'b1;
        #1;
        check("flush.in_ready_low", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        check("flush.busy", busy, 1'b0);
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.in_ready", in_ready, 1'b1);
        drive(ADD, 32'h0, 32'd5, 32'd6, 32'h0, 5'd0, 5'd9);
        tick();
        in_valid = 1'b0;
        expect_out("flush.add", 32'd11, 5'd9, 1'b0, 32'h0);
        repeat (40) tick();
        check("flush.no_late_result", out_valid, 1'b0);

        // Flush empties a stalled slot and refuses a same-cycle input
        out_ready = 1'b0;
        drive(ADD, 32'h0, 32'd1, 32'd1, 32'h0, 5'd0, 5'd4);
        tick();
        check("flush2.loaded", out_valid, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(ADD, 32'h0, 32'd2, 32'd2, 32'h0, 5'd0, 5'd5);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush2.out_valid", out_valid, 1'b0);
        tick();
        check("flush2.not_accepted", out_valid, 1'b0);

        // Reset mid-divide returns to idle with no output
        drive(DIVU, 32'h0, 32'd50, 32'd5, 32'h0, 5'd0, 5'd6);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_div.busy", busy, 1'b0);
        check("rst_div.out_valid", out_valid, 1'b0);
        check("rst_div.in_ready", in_ready, 1'b1);
        repeat (40) tick();
        check("rst_div.no_result", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
